// File: rtl/apb_controller_if.sv
// Bus bundle between the AHB slave interface and the APB controller.
// Carries the qualified AHB request, the APB pins and the AHB response.
interface apb_controller_if;
  logic        valid;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [2:0]  tempselx;
  logic        Pready;
  logic        Pslverr;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;

  modport slave (
    input  valid, Hwrite, Haddr, Hwdata, tempselx,
    input  Pready, Pslverr,
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Hreadyout, Hresp
  );

  modport master (
    output valid, Hwrite, Haddr, Hwdata, tempselx,
    output Pready, Pslverr,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Hreadyout, Hresp
  );
endinterface

// File: rtl/apb_controller.sv
// APB sequencer of the AHB-to-APB bridge.
// Runs SETUP/ACCESS, stalls AHB, maps slave errors and timeouts to ERROR.
module apb_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              Hclk,
  input  logic              Hreset,
  apb_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, WRITE,
    RENABLE, WENABLE, ERR1, ERR2
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       sel_q, sel_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  // Next-state and register-load decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        if (bus.valid) begin
          addr_d  = bus.Haddr;
          sel_d   = bus.tempselx;
          state_d = bus.Hwrite ? WWAIT : READ;
          wcnt_d  = '0;
        end
      end
      WWAIT: begin
        wdata_d = bus.Hwdata;
        wcnt_d  = '0;
        state_d = WRITE;
      end
      READ:  state_d = RENABLE;
      WRITE: state_d = WENABLE;
      RENABLE, WENABLE: begin
        if (!bus.Pready) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (TIMEOUT != 0 && wcnt_q == TO_LAST)
            state_d = ERR1;
        end else if (bus.Pslverr) begin
          state_d = ERR1;
        end else begin
          state_d = IDLE;
          if (bus.valid) begin
            addr_d  = bus.Haddr;
            sel_d   = bus.tempselx;
            state_d = bus.Hwrite ? WWAIT : READ;
            wcnt_d  = '0;
          end
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
    end
  end

  logic in_apb, in_acc;
  assign in_acc = (state_q == RENABLE) ||
                  (state_q == WENABLE);
  assign in_apb = in_acc || (state_q == READ) ||
                  (state_q == WRITE);

  assign bus.Pselx   = in_apb ? sel_q : 3'b000;
  assign bus.Penable = in_acc;
  assign bus.Pwrite  = (state_q == WRITE) ||
                       (state_q == WENABLE);
  assign bus.Paddr   = addr_q;
  assign bus.Pwdata  = wdata_q;
  assign bus.Hresp   = ((state_q == ERR1) ||
                        (state_q == ERR2)) ? 2'b01 : 2'b00;

  // AHB ready: open in idle/error-end, or on a clean APB completion.
  always_comb begin
    bus.Hreadyout = 1'b0;
    unique case (state_q)
      IDLE, ERR2:       bus.Hreadyout = 1'b1;
      RENABLE, WENABLE: bus.Hreadyout = bus.Pready & ~bus.Pslverr;
      default:          bus.Hreadyout = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller.
// Hand-computed expectations per cycle.
module tb_apb_controller;
  logic Hclk = 1'b0;
  logic Hreset;
  int   n_run = 0;
  int   n_fail = 0;
  int   acc_cnt;

  apb_controller_if bus ();

  apb_controller #(.TIMEOUT(16), .CNT_W(8)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus.slave)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic w,
                     input logic [31:0] a,
                     input logic [2:0] s);
    bus.valid    = 1'b1;
    bus.Hwrite   = w;
    bus.Haddr    = a;
    bus.tempselx = s;
  endtask

  task automatic noreq();
    bus.valid    = 1'b0;
    bus.Hwrite   = 1'b0;
    bus.Haddr    = 32'h0;
    bus.tempselx = 3'b000;
  endtask

  initial begin
    Hreset = 1'b1;
    noreq();
    bus.Hwdata  = 32'h0;
    bus.Pready  = 1'b1;
    bus.Pslverr = 1'b0;
    tick();
    tick();
    settle();
    chk("rst_psel", 32'(bus.Pselx), 32'h0);
    chk("rst_pen", 32'(bus.Penable), 32'h0);
    chk("rst_paddr", bus.Paddr, 32'h0);
    chk("rst_hrdy", 32'(bus.Hreadyout), 32'h1);
    chk("rst_hresp", 32'(bus.Hresp), 32'h0);
    Hreset = 1'b0;

    // zero-wait read
    req(1'b0, 32'h8000_0010, 3'b001);
    tick();
    noreq();
    settle();
    chk("rd_setup_sel", 32'(bus.Pselx), 32'h1);
    chk("rd_setup_pen", 32'(bus.Penable), 32'h0);
    chk("rd_setup_addr", bus.Paddr, 32'h8000_0010);
    chk("rd_setup_hrdy", 32'(bus.Hreadyout), 32'h0);
    tick();
    chk("rd_acc_pen", 32'(bus.Penable), 32'h1);
    chk("rd_acc_hrdy", 32'(bus.Hreadyout), 32'h1);
    chk("rd_acc_hresp", 32'(bus.Hresp), 32'h0);
    tick();
    chk("rd_idle_sel", 32'(bus.Pselx), 32'h0);

    // zero-wait write
    req(1'b1, 32'h8400_0004, 3'b010);
    tick();
    noreq();
    bus.Hwdata = 32'hDEAD_BEEF;
    settle();
    chk("wr_wwait_hrdy", 32'(bus.Hreadyout), 32'h0);
    chk("wr_wwait_sel", 32'(bus.Pselx), 32'h0);
    tick();
    chk("wr_setup_sel", 32'(bus.Pselx), 32'h2);
    chk("wr_setup_pwr", 32'(bus.Pwrite), 32'h1);
    chk("wr_setup_pwd", bus.Pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_pen", 32'(bus.Penable), 32'h0);
    chk("wr_setup_addr", bus.Paddr, 32'h8400_0004);
    tick();
    chk("wr_acc_pen", 32'(bus.Penable), 32'h1);
    chk("wr_acc_hrdy", 32'(bus.Hreadyout), 32'h1);
    tick();

    // read with three wait states
    req(1'b0, 32'h8800_0000, 3'b100);
    tick();
    noreq();
    bus.Pready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rdw_hrdy", 32'(bus.Hreadyout), 32'h0);
      chk("rdw_sel", 32'(bus.Pselx), 32'h4);
      chk("rdw_addr", bus.Paddr, 32'h8800_0000);
      chk("rdw_pen", 32'(bus.Penable), 32'h1);
      tick();
    end
    bus.Pready = 1'b1;
    settle();
    chk("rdw_last_hrdy", 32'(bus.Hreadyout), 32'h1);
    chk("rdw_last_sel", 32'(bus.Pselx), 32'h4);
    tick();

    // write ending in slave error
    req(1'b1, 32'h8000_0020, 3'b001);
    tick();
    noreq();
    bus.Hwdata = 32'h1234_5678;
    tick();
    tick();
    bus.Pslverr = 1'b1;
    settle();
    chk("err_acc_hrdy", 32'(bus.Hreadyout), 32'h0);
    tick();
    bus.Pslverr = 1'b0;
    settle();
    chk("err1_hresp", 32'(bus.Hresp), 32'h1);
    chk("err1_hrdy", 32'(bus.Hreadyout), 32'h0);
    chk("err1_sel", 32'(bus.Pselx), 32'h0);
    tick();
    chk("err2_hresp", 32'(bus.Hresp), 32'h1);
    chk("err2_hrdy", 32'(bus.Hreadyout), 32'h1);
    chk("err2_sel", 32'(bus.Pselx), 32'h0);
    tick();
    chk("err_idle_hresp", 32'(bus.Hresp), 32'h0);

    // timeout
    req(1'b0, 32'h8000_0040, 3'b001);
    tick();
    noreq();
    bus.Pready = 1'b0;
    tick();
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Penable !== 1'b1) break;
      acc_cnt++;
      tick();
    end
    chk("to_cycles", 32'(acc_cnt), 32'd16);
    chk("to_err1_hresp", 32'(bus.Hresp), 32'h1);
    chk("to_err1_hrdy", 32'(bus.Hreadyout), 32'h0);
    chk("to_err1_sel", 32'(bus.Pselx), 32'h0);
    bus.Pready = 1'b1;
    tick();
    bus.Pready = 1'b0;
    settle();
    chk("to_err2_hresp", 32'(bus.Hresp), 32'h1);
    chk("to_err2_pen", 32'(bus.Penable), 32'h0);
    tick();
    chk("to_idle_hresp", 32'(bus.Hresp), 32'h0);
    chk("to_idle_sel", 32'(bus.Pselx), 32'h0);
    bus.Pready = 1'b1;

    // back-to-back write then read
    req(1'b1, 32'h8400_0008, 3'b010);
    tick();
    noreq();
    bus.Hwdata = 32'hCAFE_F00D;
    tick();
    tick();
    req(1'b0, 32'h8000_0030, 3'b001);
    settle();
    chk("b2b_wacc_hrdy", 32'(bus.Hreadyout), 32'h1);
    tick();
    noreq();
    settle();
    chk("b2b_rd_sel", 32'(bus.Pselx), 32'h1);
    chk("b2b_rd_pwr", 32'(bus.Pwrite), 32'h0);
    chk("b2b_rd_pen", 32'(bus.Penable), 32'h0);
    chk("b2b_rd_addr", bus.Paddr, 32'h8000_0030);
    tick();
    req(1'b1, 32'h8400_000C, 3'b010);
    tick();
    noreq();
    bus.Hwdata = 32'h5555_AAAA;
    tick();
    tick();
    chk("rst_mid_pen", 32'(bus.Penable), 32'h1);
    bus.Pready = 1'b0;
    Hreset = 1'b1;
    tick();
    Hreset = 1'b0;
    bus.Pready = 1'b1;
    settle();
    chk("rstm_sel", 32'(bus.Pselx), 32'h0);
    chk("rstm_pen", 32'(bus.Penable), 32'h0);
    chk("rstm_pwr", 32'(bus.Pwrite), 32'h0);
    chk("rstm_paddr", bus.Paddr, 32'h0);
    chk("rstm_pwd", bus.Pwdata, 32'h0);
    chk("rstm_hrdy", 32'(bus.Hreadyout), 32'h1);
    chk("rstm_hresp", 32'(bus.Hresp), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
